// File: rtl/load_store_unit_if.sv
// Word-wide data-memory bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_rdata, mem_ready);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    output mem_rdata, mem_ready);
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: byte/half/word loads and stores over a req/ready bus.
// Optional access timeout abort is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic                  ex_is_store,
    input  logic [2:0]            ex_funct3,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [31:0]           ex_store_data,
    input  logic [4:0]            ex_rd,
    output logic                  lsu_busy,
    load_store_unit_if.master     mem,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  lsu_fault
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t      state_r, state_n_s;
    logic        reject_s, illegal_s, start_s, fault_s, done_s, abort_s;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic [4:0]  rd_r;
    logic        is_load_r;

    // Returns {wdata, wstrb}: narrow data replicated across lanes, strobe shifted to the offset.
    function automatic logic [35:0] encode_store(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] d);
        logic [35:0] r;
        case (f3[1:0])
            2'b00:   r = {{4{d[7:0]}}, 4'b0001 << off};
            2'b01:   r = {{2{d[15:0]}}, 4'b0011 << off};
            default: r = {d, 4'b1111};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Request legality: unknown funct3, unsigned stores, misalignment, or load+store together.
    always_comb begin
        illegal_s = 1'b0;
        case (ex_funct3)
            3'b000:  illegal_s = 1'b0;
            3'b001:  illegal_s = ex_addr[0];
            3'b010:  illegal_s = (ex_addr[1:0] != 2'b00);
            3'b100:  illegal_s = ex_is_store;
            3'b101:  illegal_s = ex_is_store | ex_addr[0];
            default: illegal_s = 1'b1;
        endcase
        if (ex_is_load && ex_is_store) begin
            reject_s = 1'b1;
        end else begin
            reject_s = illegal_s;
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             tmo_hit_s;
    assign tmo_hit_s = (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts ACCESS cycles spent waiting for mem_ready; restarts on every new access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if (start_s) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ACCESS && !mem.mem_ready) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end
    end
`endif

    // Next-state and one-cycle event decode.
    always_comb begin
        state_n_s = state_r;
        start_s   = 1'b0;
        fault_s   = 1'b0;
        done_s    = 1'b0;
        abort_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (ex_valid && (ex_is_load || ex_is_store)) begin
                    if (reject_s) begin
                        fault_s = 1'b1;
                    end else begin
                        start_s   = 1'b1;
                        state_n_s = ACCESS;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem.mem_ready) begin
                    done_s    = 1'b1;
                    state_n_s = is_load_r ? RESP : IDLE;
                end else begin
`ifdef LSU_TIMEOUT_EN
                    if (tmo_hit_s) begin
                        abort_s   = 1'b1;
                        state_n_s = IDLE;
                    end else begin
                        state_n_s = ACCESS;
                    end
`else
                    state_n_s = ACCESS;
`endif
                end
            end
            RESP:    state_n_s = IDLE;
            default: state_n_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Bus, writeback and status outputs, all registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lsu_busy      <= 1'b0;
            lsu_fault     <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= 32'd0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= 32'd0;
            mem.mem_wstrb <= 4'd0;
            funct3_r      <= 3'd0;
            off_r         <= 2'd0;
            rd_r          <= 5'd0;
            is_load_r     <= 1'b0;
        end else begin
            lsu_busy  <= (state_n_s != IDLE);
            lsu_fault <= fault_s | abort_s;
            wb_valid  <= done_s & is_load_r;
            if (start_s) begin
                mem.mem_req  <= 1'b1;
                mem.mem_we   <= ex_is_store;
                mem.mem_addr <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
                {mem.mem_wdata, mem.mem_wstrb} <= ex_is_store ?
                    encode_store(ex_funct3, ex_addr[1:0], ex_store_data) : 36'd0;
                funct3_r     <= ex_funct3;
                off_r        <= ex_addr[1:0];
                rd_r         <= ex_rd;
                is_load_r    <= ex_is_load;
            end else if (done_s || abort_s) begin
                mem.mem_req <= 1'b0;
            end
            if (done_s && is_load_r) begin
                wb_rd   <= rd_r;
                wb_data <= format_load(funct3_r, off_r, mem.mem_rdata);
            end
        end
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage of the RiscVCPU datapath, directly downstream of the ALU/execute stage. Takes the effective address from the ALU and the store data from RegisterFile, then runs one load or store (LB/LH/LW/LBU/LHU/SB/SH/SW) against a word-wide data memory over a req/ready handshake. Load results are formatted and handed to register-file writeback. Misaligned and illegal requests are rejected without touching memory.

Parameters:
ADDR_WIDTH, 32, byte-address width of ex_addr and mem_addr.
TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; used only with LSU_TIMEOUT_EN.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
ex_valid  input  1  execute stage presents a memory op this cycle.
ex_is_load  input  1  op is a load.
ex_is_store  input  1  op is a store.
ex_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
ex_addr  input  ADDR_WIDTH  effective byte address from ALU.
ex_store_data  input  32  rs2 value.
ex_rd  input  5  load destination register.
lsu_busy  output  1  high when state != IDLE; upstream holds its op and stalls.
mem_req  output  1  memory request, held until mem_ready.
mem_we  output  1  1 = write.
mem_addr  output  ADDR_WIDTH  word-aligned address {ex_addr[ADDR_WIDTH-1:2], 2'b00}.
mem_wdata  output  32  replicated store data.
mem_wstrb  output  4  byte enables; 0000 on reads.
mem_rdata  input  32  read word, valid when mem_ready is high.
mem_ready  input  1  completes the access in the current cycle.
wb_valid  output  1  one-cycle pulse: load result available.
wb_rd  output  5  destination register.
wb_data  output  32  formatted load data.
lsu_fault  output  1  one-cycle pulse: misaligned or illegal request rejected.

Behaviour:
- Reset: state=IDLE. All outputs 0, including lsu_busy, mem_req, wb_valid and lsu_fault. Any in-flight access is abandoned with no writeback.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, when ex_valid and exactly one of ex_is_load/ex_is_store is set:
  - Fault cases: funct3 illegal (011, 110, 111, or 100/101 with a store), H at addr[0]=1, or W at addr[1:0]!=0. Next cycle lsu_fault=1 for one cycle; stay IDLE; no memory activity.
  - Otherwise register addr, funct3, rd, byte offset, wdata and wstrb; go to ACCESS.
- IDLE, both ex_is_load and ex_is_store set: fault. Neither set: ignored.
- ACCESS: mem_req=1. mem_we, mem_addr, mem_wdata and mem_wstrb stay stable until mem_ready is sampled high.
  - Store completes: return to IDLE; no wb_valid.
  - Load completes: capture formatted mem_rdata; go to RESP.
- RESP: wb_valid=1, wb_rd and wb_data valid for exactly one cycle, then IDLE. ex_valid in RESP is ignored (busy).
- Store encoding:
  - SB: wdata = {4{data[7:0]}}, wstrb = 0001 << off.
  - SH: wdata = {2{data[15:0]}}, wstrb = 0011 << off.
  - SW: wdata = data, wstrb = 1111.
- Load formatting: select byte/half at offset. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- rd=0 loads still access memory and pulse wb_valid with wb_rd=0; the register file discards them.
- Latency: with mem_ready tied high, a store takes 2 cycles from accept to IDLE. A load's wb_valid is 2 cycles after the accepting edge. Back-to-back ops: the next op is accepted in the first IDLE cycle.
- Reset mid-ACCESS: mem_req drops asynchronously; no wb_valid or lsu_fault follows.

Optional Feature:
LSU_TIMEOUT_EN. When defined:
- A counter clears on entry to ACCESS and increments each cycle mem_ready is low.
- On reaching TIMEOUT_CYCLES, drop mem_req, pulse lsu_fault for one cycle, return to IDLE, and produce no writeback.

When undefined: no counter; ACCESS waits indefinitely for mem_ready.

Test Plan:
- Reset asserted mid-ACCESS -> mem_req, lsu_busy and wb_valid go to 0 immediately; no writeback after release.
- SW x4=0x00000004 at addr 0x00000008, mem_ready high -> mem_addr=0x8, mem_wstrb=1111, mem_wdata=0x00000004, mem_we=1; lsu_busy low 2 cycles after accept; wb_valid never set.
- SB 0x000000A5 at 0x13 -> mem_addr=0x10, wstrb=1000, wdata=0xA5A5A5A5.
- LB rd=5 at 0x11 with rdata=0x1234_80FF -> wb_valid pulse 2 cycles after accept, wb_rd=5, wb_data=0xFFFFFF80. LBU at the same address gives 0x00000080. LH at 0x12 gives 0x00001234.
- LW at 0x6 and SH at 0x3 -> lsu_fault single pulse each, mem_req never asserted, lsu_busy stays 0.
- mem_ready held low 5 cycles during a load -> mem_req and mem_addr stable throughout; wb_valid one cycle after ready. With LSU_TIMEOUT_EN and ready held low: lsu_fault after 16 cycles, then IDLE.
